// File: rtl/hwpf_stride_pkg.sv
// Shared types for the stride prefetcher: engine CSR words, status
// layout and the descriptor sequencer bundle/states.
package hwpf_stride_pkg;

  typedef struct packed {
    logic [59:0] base_cline;
    logic        upstream;
    logic        cycle;
    logic        rearm;
    logic        enable;
  } hwpf_stride_base_t;

  typedef struct packed {
    logic [15:0] nblocks;
    logic [15:0] nlines;
    logic [31:0] stride;
  } hwpf_stride_param_t;

  typedef struct packed {
    logic [15:0] ninflight;
    logic [15:0] nwait;
  } hwpf_stride_throttle_t;

  typedef logic [63:0] hwpf_stride_status_t;

  typedef struct packed {
    hwpf_stride_base_t     base;
    hwpf_stride_param_t    param;
    hwpf_stride_throttle_t throttle;
  } hwpf_stride_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PARAM    = 3'd1,
    ST_THROTTLE = 3'd2,
    ST_BASE     = 3'd3,
    ST_WAIT     = 3'd4
  } hwpf_stride_seq_state_e;

  localparam int unsigned HWPF_STRIDE_STATUS_EN_LSB   = 0;
  localparam int unsigned HWPF_STRIDE_STATUS_EN_MSB   = 15;
  localparam int unsigned HWPF_STRIDE_STATUS_FIDX_LSB = 16;
  localparam int unsigned HWPF_STRIDE_STATUS_FIDX_MSB = 19;
  localparam int unsigned HWPF_STRIDE_STATUS_FREE     = 31;
  localparam int unsigned HWPF_STRIDE_STATUS_BUSY_LSB = 32;
  localparam int unsigned HWPF_STRIDE_STATUS_BUSY_MSB = 47;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// Register-based FIFO with synchronous flush (flush beats push/pop).
// Ports: w_i/wok_o/wdata_i push side, r_i/rok_o/rdata_o pop side.
module hpdcache_fifo_reg #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter type fifo_data_t = logic
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       w_i,
  output logic       wok_o,
  input  fifo_data_t wdata_i,
  input  logic       r_i,
  output logic       rok_o,
  output fifo_data_t rdata_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  fifo_data_t      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     cnt;
  logic            push;
  logic            pop;

  assign wok_o   = cnt < (AW+1)'(FIFO_DEPTH);
  assign rok_o   = cnt != '0;
  assign rdata_o = mem[rptr];
  assign push    = w_i & wok_o & ~flush_i;
  assign pop     = r_i & rok_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/hwpf_stride_seq.sv
// Descriptor sequencer: queues descriptors, programs a free engine
// param->throttle->base(enable), merges with sw CSR writes (sw wins)
// and reports completion of owned engines.
// Ports: desc_* push queue, sw_* software CSR writes, status in,
// hwpf_stride_* merged CSR writes out, alloc_*/done_* event pulses.
module hwpf_stride_seq
  import hwpf_stride_pkg::*;
#(
  parameter int unsigned NUM_HW_PREFETCH = 4,
  parameter int unsigned DESC_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic desc_valid_i,
  output logic desc_ready_o,
  input  hwpf_stride_base_t     desc_base_i,
  input  hwpf_stride_param_t    desc_param_i,
  input  hwpf_stride_throttle_t desc_throttle_i,
  input  logic flush_i,
  input  logic [NUM_HW_PREFETCH-1:0] sw_base_set_i,
  input  logic [NUM_HW_PREFETCH-1:0] sw_param_set_i,
  input  logic [NUM_HW_PREFETCH-1:0] sw_throttle_set_i,
  input  hwpf_stride_base_t     [NUM_HW_PREFETCH-1:0] sw_base_i,
  input  hwpf_stride_param_t    [NUM_HW_PREFETCH-1:0] sw_param_i,
  input  hwpf_stride_throttle_t [NUM_HW_PREFETCH-1:0] sw_throttle_i,
  input  hwpf_stride_status_t hwpf_stride_status_i,
  output logic [NUM_HW_PREFETCH-1:0] hwpf_stride_base_set_o,
  output logic [NUM_HW_PREFETCH-1:0] hwpf_stride_param_set_o,
  output logic [NUM_HW_PREFETCH-1:0] hwpf_stride_throttle_set_o,
  output hwpf_stride_base_t     [NUM_HW_PREFETCH-1:0] hwpf_stride_base_o,
  output hwpf_stride_param_t    [NUM_HW_PREFETCH-1:0] hwpf_stride_param_o,
  output hwpf_stride_throttle_t [NUM_HW_PREFETCH-1:0] hwpf_stride_throttle_o,
  output logic       alloc_valid_o,
  output logic [3:0] alloc_idx_o,
  output logic       done_valid_o,
  output logic [3:0] done_idx_o,
  output logic       idle_o
);

  localparam int unsigned N = NUM_HW_PREFETCH;

  hwpf_stride_seq_state_e state;
  hwpf_stride_seq_state_e state_nxt;
  logic [3:0]        idx;
  logic [N-1:0]      owned;
  hwpf_stride_desc_t q_wdata;
  hwpf_stride_desc_t q_rdata;
  logic              q_rok;
  logic              q_pop;
  logic              seq_go;
  logic              own_set;

  logic [3:0]   free_idx;
  logic         free_ok;
  logic [N-1:0] st_en;
  logic [N-1:0] st_busy;
  logic         unused_status;

  assign free_idx = hwpf_stride_status_i[HWPF_STRIDE_STATUS_FIDX_MSB:
                                         HWPF_STRIDE_STATUS_FIDX_LSB];
  assign free_ok  = hwpf_stride_status_i[HWPF_STRIDE_STATUS_FREE];
  assign st_en    = hwpf_stride_status_i[HWPF_STRIDE_STATUS_EN_LSB +: N];
  assign st_busy  = hwpf_stride_status_i[HWPF_STRIDE_STATUS_BUSY_LSB +: N];
  assign unused_status = ^hwpf_stride_status_i;

  // 16-wide copies so a 4-bit index never leaves the vector
  logic [15:0] sw_bs;
  logic [15:0] sw_ps;
  logic [15:0] sw_ts;
  logic [15:0] sw_en;
  logic [N-1:0] sw_en_n;

  for (genvar i = 0; i < N; i++) begin : g_swen
    assign sw_en_n[i] = sw_base_i[i].enable;
  end

  assign sw_bs = 16'(sw_base_set_i);
  assign sw_ps = 16'(sw_param_set_i);
  assign sw_ts = 16'(sw_throttle_set_i);
  assign sw_en = 16'(sw_en_n);

  logic pick_ok;
  logic abort;

  assign pick_ok = free_ok && (32'(free_idx) < N)
                && !(sw_bs[free_idx] | sw_ps[free_idx] | sw_ts[free_idx]);
  assign abort   = sw_bs[idx] & sw_en[idx];

  assign q_wdata.base     = desc_base_i;
  assign q_wdata.param    = desc_param_i;
  assign q_wdata.throttle = desc_throttle_i;

  hpdcache_fifo_reg #(
    .FIFO_DEPTH  (DESC_DEPTH),
    .fifo_data_t (hwpf_stride_desc_t)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .w_i     (desc_valid_i),
    .wok_o   (desc_ready_o),
    .wdata_i (q_wdata),
    .r_i     (q_pop),
    .rok_o   (q_rok),
    .rdata_o (q_rdata)
  );

  always_comb begin
    state_nxt = state;
    seq_go    = 1'b0;
    q_pop     = 1'b0;
    own_set   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (q_rok && pick_ok && !flush_i) state_nxt = ST_PARAM;
      end
      ST_PARAM: begin
        if (abort || flush_i) begin
          state_nxt = ST_IDLE;
        end else if (!sw_ps[idx]) begin
          seq_go    = 1'b1;
          state_nxt = ST_THROTTLE;
        end
      end
      ST_THROTTLE: begin
        if (abort || flush_i) begin
          state_nxt = ST_IDLE;
        end else if (!sw_ts[idx]) begin
          seq_go    = 1'b1;
          state_nxt = ST_BASE;
        end
      end
      ST_BASE: begin
        // a flush here still lets the enable write land
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!sw_bs[idx]) begin
          seq_go    = 1'b1;
          q_pop     = 1'b1;
          own_set   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic [N-1:0] oh;
  logic [N-1:0] seq_bset;
  logic [N-1:0] seq_pset;
  logic [N-1:0] seq_tset;
  logic         go;

  assign go = seq_go & ~rst_i;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      oh[i] = (idx == 4'(i));
    end
  end

  assign seq_pset = (go && state == ST_PARAM)    ? oh : '0;
  assign seq_tset = (go && state == ST_THROTTLE) ? oh : '0;
  assign seq_bset = (go && state == ST_BASE)     ? oh : '0;

  hwpf_stride_base_t seq_base;

  always_comb begin
    seq_base        = q_rdata.base;
    seq_base.enable = 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_merge
    assign hwpf_stride_base_set_o[i] = sw_base_set_i[i] | seq_bset[i];
    assign hwpf_stride_param_set_o[i] = sw_param_set_i[i] | seq_pset[i];
    assign hwpf_stride_throttle_set_o[i] =
      sw_throttle_set_i[i] | seq_tset[i];
    assign hwpf_stride_base_o[i] =
      sw_base_set_i[i] ? sw_base_i[i] :
      seq_bset[i]      ? seq_base     : '0;
    assign hwpf_stride_param_o[i] =
      sw_param_set_i[i] ? sw_param_i[i]  :
      seq_pset[i]       ? q_rdata.param  : '0;
    assign hwpf_stride_throttle_o[i] =
      sw_throttle_set_i[i] ? sw_throttle_i[i]  :
      seq_tset[i]          ? q_rdata.throttle  : '0;
  end

  // the engine just enabled is masked in WAIT: its status lags a cycle
  logic [N-1:0] fin;
  logic [N-1:0] fin_clr;
  logic         fin_any;
  logic [3:0]   fin_idx;

  always_comb begin
    fin = owned & ~st_en & ~st_busy;
    if (state == ST_WAIT) fin = fin & ~oh;
    fin_any = |fin;
    fin_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (fin[i]) fin_idx = 4'(i);
    end
    for (int i = 0; i < N; i++) begin
      fin_clr[i] = fin_any && (fin_idx == 4'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      idx          <= '0;
      owned        <= '0;
      done_valid_o <= 1'b0;
      done_idx_o   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_PARAM) idx <= free_idx;
      owned <= (owned & ~fin_clr) | (own_set ? oh : '0);
      done_valid_o <= fin_any;
      if (fin_any) done_idx_o <= fin_idx;
    end
  end

  assign alloc_valid_o = (state == ST_WAIT);
  assign alloc_idx_o   = idx;
  assign idle_o        = !q_rok && state == ST_IDLE && owned == '0;

endmodule

// File: tb/tb_hwpf_stride_seq.sv
// Directed bench for hwpf_stride_seq: programming order, queue full,
// sw stall/abort, flush and completion ordering.
module tb_hwpf_stride_seq;
  import hwpf_stride_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic desc_valid, desc_ready, flush;
  hwpf_stride_base_t     d_base;
  hwpf_stride_param_t    d_param;
  hwpf_stride_throttle_t d_thr;
  logic [N-1:0] sw_bs, sw_ps, sw_ts;
  hwpf_stride_base_t     [N-1:0] sw_b;
  hwpf_stride_param_t    [N-1:0] sw_p;
  hwpf_stride_throttle_t [N-1:0] sw_t;
  hwpf_stride_status_t status;
  logic [N-1:0] bset, pset, tset;
  hwpf_stride_base_t     [N-1:0] bo;
  hwpf_stride_param_t    [N-1:0] po;
  hwpf_stride_throttle_t [N-1:0] to;
  logic alloc_v, done_v, idle;
  logic [3:0] alloc_idx, done_idx;

  logic [3:0] en, busy, fidx;
  logic fok;
  assign status = {16'h0, 12'h0, busy, fok, 11'h0, fidx, 12'h0, en};

  hwpf_stride_seq #(.NUM_HW_PREFETCH(N), .DESC_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
    .desc_base_i(d_base), .desc_param_i(d_param),
    .desc_throttle_i(d_thr), .flush_i(flush),
    .sw_base_set_i(sw_bs), .sw_param_set_i(sw_ps),
    .sw_throttle_set_i(sw_ts),
    .sw_base_i(sw_b), .sw_param_i(sw_p), .sw_throttle_i(sw_t),
    .hwpf_stride_status_i(status),
    .hwpf_stride_base_set_o(bset), .hwpf_stride_param_set_o(pset),
    .hwpf_stride_throttle_set_o(tset),
    .hwpf_stride_base_o(bo), .hwpf_stride_param_o(po),
    .hwpf_stride_throttle_o(to),
    .alloc_valid_o(alloc_v), .alloc_idx_o(alloc_idx),
    .done_valid_o(done_v), .done_idx_o(done_idx), .idle_o(idle)
  );

  int checks = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic hwpf_stride_desc_t mk(input int k);
    hwpf_stride_desc_t d;
    d.base            = '0;
    d.base.base_cline = 60'(32'h1000 + k);
    d.base.rearm      = 1'b1;
    d.param.nblocks   = 16'(k);
    d.param.nlines    = 16'(k + 1);
    d.param.stride    = 32'(k * 64);
    d.throttle.ninflight = 16'(k + 2);
    d.throttle.nwait     = 16'(k + 3);
    return d;
  endfunction

  task automatic push(input int k);
    hwpf_stride_desc_t d;
    d = mk(k);
    desc_valid = 1'b1;
    d_base  = d.base;
    d_param = d.param;
    d_thr   = d.throttle;
  endtask

  function automatic hwpf_stride_base_t eb(input int k);
    hwpf_stride_desc_t d;
    d = mk(k);
    d.base.enable = 1'b1;
    return d.base;
  endfunction

  function automatic hwpf_stride_param_t ep(input int k);
    hwpf_stride_desc_t d;
    d = mk(k);
    return d.param;
  endfunction

  function automatic hwpf_stride_throttle_t et(input int k);
    hwpf_stride_desc_t d;
    d = mk(k);
    return d.throttle;
  endfunction

  hwpf_stride_param_t swp;
  hwpf_stride_base_t  swb;

  initial begin
    rst = 1'b1; desc_valid = 1'b0; flush = 1'b0;
    d_base = '0; d_param = '0; d_thr = '0;
    sw_bs = '0; sw_ps = '0; sw_ts = '0;
    sw_b = '0; sw_p = '0; sw_t = '0;
    en = '0; busy = '0; fok = 1'b0; fidx = '0;
    swp = '{nblocks: 16'hAAAA, nlines: 16'h5555, stride: 32'hDEAD};
    swb = '0; swb.base_cline = 60'hBEEF; swb.enable = 1'b1;

    cyc(); cyc(); #2;
    chk("rst_ready", 64'(desc_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_sets", 64'({bset, pset, tset}), 64'd0);
    chk("rst_alloc", 64'({alloc_v, alloc_idx}), 64'd0);
    chk("rst_done", 64'({done_v, done_idx}), 64'd0);
    chk("rst_bdata", 64'(|{bo, po, to}), 64'd0);
    cyc(); rst = 1'b0;

    // single descriptor on engine 2
    cyc(); fok = 1'b1; fidx = 4'd2; push(10); #2;
    chk("t1_idle_pre", 64'(idle), 64'd1);
    cyc(); desc_valid = 1'b0; #2;
    chk("t1_idle_q", 64'(idle), 64'd0);
    chk("t1_nopset", 64'(pset), 64'd0);
    cyc(); #2;
    chk("t1_pset", 64'(pset), 64'b0100);
    chk("t1_pdata", 64'(po[2]), 64'(ep(10)));
    cyc(); #2;
    chk("t1_tset", 64'(tset), 64'b0100);
    chk("t1_tdata", 64'(to[2]), 64'(et(10)));
    cyc(); #2;
    chk("t1_bset", 64'(bset), 64'b0100);
    chk("t1_bdata", 64'(bo[2]), 64'(eb(10)));
    cyc(); en[2] = 1'b1; fok = 1'b0; #2;
    chk("t1_alloc", 64'({alloc_v, alloc_idx}), 64'h12);
    cyc(); #2;
    chk("t1_alloc_off", 64'(alloc_v), 64'd0);
    chk("t1_nodone", 64'(done_v), 64'd0);

    // fill the queue with no free engine
    for (int k = 0; k < 4; k++) begin
      cyc(); push(k);
    end
    cyc(); desc_valid = 1'b0; #2;
    chk("t2_full", 64'(desc_ready), 64'd0);
    chk("t2_nosets", 64'({bset, pset, tset}), 64'd0);
    cyc(); fok = 1'b1; fidx = 4'd0; #2;
    chk("t2_pick_nopset", 64'(pset), 64'd0);
    cyc(); fok = 1'b0; #2;
    chk("t2_pset", 64'(pset), 64'b0001);
    chk("t2_pdata", 64'(po[0]), 64'(ep(0)));
    cyc(); #2;
    chk("t2_tset", 64'(tset), 64'b0001);
    cyc(); #2;
    chk("t2_bset", 64'(bset), 64'b0001);
    chk("t2_full_base", 64'(desc_ready), 64'd0);
    cyc(); en[0] = 1'b1; #2;
    chk("t2_ready", 64'(desc_ready), 64'd1);
    chk("t2_alloc", 64'({alloc_v, alloc_idx}), 64'h10);

    // sw param write stalls programming of engine 1
    cyc(); fok = 1'b1; fidx = 4'd1; #2;
    cyc(); fok = 1'b0; sw_ps = 4'b0010; sw_p[1] = swp; #2;
    chk("t3_sw_pset", 64'(pset), 64'b0010);
    chk("t3_sw_pdata", 64'(po[1]), 64'(swp));
    cyc(); sw_ps = '0; #2;
    chk("t3_pset", 64'(pset), 64'b0010);
    chk("t3_pdata", 64'(po[1]), 64'(ep(1)));
    chk("t3_notset", 64'(tset), 64'd0);
    cyc(); #2;
    chk("t3_tset", 64'(tset), 64'b0010);
    cyc(); #2;
    chk("t3_bdata", 64'(bo[1]), 64'(eb(1)));
    cyc(); en[1] = 1'b1; #2;
    chk("t3_alloc", 64'({alloc_v, alloc_idx}), 64'h11);

    // sw enable on engine 3 aborts, descriptor moves to engine 0
    cyc(); fok = 1'b1; fidx = 4'd3; #2;
    cyc(); fok = 1'b0; #2;
    chk("t4_pset", 64'(pset), 64'b1000);
    chk("t4_pdata", 64'(po[3]), 64'(ep(2)));
    cyc(); sw_bs = 4'b1000; sw_b[3] = swb; #2;
    chk("t4_sw_bset", 64'(bset), 64'b1000);
    chk("t4_sw_bdata", 64'(bo[3]), 64'(swb));
    chk("t4_notset", 64'(tset), 64'd0);
    cyc(); sw_bs = '0; fok = 1'b1; fidx = 4'd0; #2;
    chk("t4_abort_sets", 64'({bset, tset}), 64'd0);
    chk("t4_noalloc", 64'(alloc_v), 64'd0);
    cyc(); fok = 1'b0; #2;
    chk("t4_re_pset", 64'(pset), 64'b0001);
    chk("t4_re_pdata", 64'(po[0]), 64'(ep(2)));
    cyc(); #2;
    chk("t4_re_tdata", 64'(to[0]), 64'(et(2)));
    cyc(); #2;
    chk("t4_re_bset", 64'(bset), 64'b0001);
    chk("t4_re_bdata", 64'(bo[0]), 64'(eb(2)));
    cyc(); #2;
    chk("t4_alloc", 64'({alloc_v, alloc_idx}), 64'h10);

    // flush with three queued while in PARAM
    cyc(); push(4);
    cyc(); push(5);
    cyc(); desc_valid = 1'b0; fok = 1'b1; fidx = 4'd3; #2;
    chk("t6_ready", 64'(desc_ready), 64'd1);
    cyc(); fok = 1'b0; flush = 1'b1; push(6); #2;
    cyc(); flush = 1'b0; desc_valid = 1'b0; fok = 1'b1; #2;
    chk("t6_sets", 64'({bset, tset}), 64'd0);
    chk("t6_ready2", 64'(desc_ready), 64'd1);
    cyc(); #2;
    chk("t6_nopset", 64'(pset), 64'd0);
    cyc(); #2;
    chk("t6_nopset2", 64'({pset, tset}), 64'd0);
    cyc(); fok = 1'b0; #2;
    chk("t6_nobset", 64'(bset), 64'd0);
    chk("t6_idle_owned", 64'(idle), 64'd0);

    // completion ordering
    cyc(); en[0] = 1'b0; #2;
    chk("t5_nodone", 64'(done_v), 64'd0);
    cyc(); #2;
    chk("t5_done0", 64'({done_v, done_idx}), 64'h10);
    cyc(); en[1] = 1'b0; en[2] = 1'b0; #2;
    chk("t5_gap", 64'(done_v), 64'd0);
    chk("t5_busy_idle", 64'(idle), 64'd0);
    cyc(); #2;
    chk("t5_done1", 64'({done_v, done_idx}), 64'h11);
    cyc(); #2;
    chk("t5_done2", 64'({done_v, done_idx}), 64'h12);
    cyc(); #2;
    chk("t5_done_off", 64'(done_v), 64'd0);
    chk("t5_idle", 64'(idle), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/hwpf_stride_seq.md
# hwpf_stride_seq

Descriptor sequencer for the stride prefetcher engine array. Accepts prefetch descriptors (base, param and throttle words) from a queue-style push interface. For each descriptor it picks a free engine from the array status and programs that engine's three CSRs in a fixed order, ending with an enable write. It merges its CSR writes with direct software CSR writes (software wins), and reports each engine's completion. It sits between the core-side configuration path and the prefetcher wrapper's CSR set/data inputs.

## Interface
- NUM_HW_PREFETCH, 4, number of engines (1..16)
- DESC_DEPTH, 4, descriptor queue entries (power of 2, ≥2)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- desc_valid_i  in  1  descriptor push valid
- desc_ready_o  out  1  queue not full
- desc_base_i  in  hwpf_stride_base_t  base word (enable field ignored)
- desc_param_i  in  hwpf_stride_param_t  param word
- desc_throttle_i  in  hwpf_stride_throttle_t  throttle word
- flush_i  in  1  drop all queued (not yet popped) descriptors
- sw_base_set_i / sw_param_set_i / sw_throttle_set_i  in  [NUM_HW_PREFETCH]  software CSR write strobes
- sw_base_i / sw_param_i / sw_throttle_i  in  [NUM_HW_PREFETCH] of pkg types  software CSR data
- hwpf_stride_status_i  in  hwpf_stride_status_t (64)  array status: [15:0] enable, [19:16] free idx, [31] any free, [47:32] busy
- hwpf_stride_{base,param,throttle}_set_o  out  [NUM_HW_PREFETCH]  merged set strobes to engines
- hwpf_stride_{base,param,throttle}_o  out  [NUM_HW_PREFETCH] of pkg types  merged CSR data
- alloc_valid_o  out  1  one-cycle pulse: descriptor bound to engine
- alloc_idx_o  out  4  engine index for alloc_valid_o
- done_valid_o  out  1  one-cycle pulse: owned engine finished
- done_idx_o  out  4  finished engine index
- idle_o  out  1  queue empty, FSM IDLE, no owned engine

## Operation
- The queue holds {base, param, throttle}.
- Push: desc_valid_i & desc_ready_o.
- Pop: only on a successful BASE write.
- desc_ready_o = (count < DESC_DEPTH). There is no bypass when full.
- FSM states and transitions:
  - IDLE: if the queue is non-empty, status[31]=1 and no sw strobe targets status[19:16], latch idx ← status[19:16] and go to PARAM.
  - PARAM: drive param_set_o[idx] with the queued param, then go to THROTTLE.
  - THROTTLE: drive throttle_set_o[idx] with the queued throttle, then go to BASE.
  - BASE: drive base_set_o[idx] with the queued base, enable forced to 1; pop; set owned[idx]; go to WAIT.
  - WAIT: pulse alloc_valid_o with alloc_idx_o=idx; return to IDLE. This one cycle lets the status enable bit register before the next pick.
- Stall and abort rules in PARAM/THROTTLE/BASE:
  - A sw strobe of the same kind to idx in that cycle: sw data is driven and the FSM holds its state (retry next cycle).
  - sw_base_set_i[idx] with .enable=1 in any of these states: abort to IDLE, no pop, no alloc pulse. The descriptor stays queued for another engine.
- Merge, per engine i and kind k: set_o = sw_set_i | seq_set. Data = sw_set_i ? sw data : sequencer data.
- Completion: an engine is finished when owned[i] & !enable[i] & !busy[i], sampled one cycle after WAIT or later.
  - One done pulse per cycle, lowest index first; owned[i] is cleared on its pulse.
  - Other finished engines stay pending.
- sw_base_set_i[i] with .enable=0 on an owned engine does not clear owned[i]; completion then fires normally.
- flush_i: count ← 0 the next cycle.
  - The descriptor in flight (PARAM/THROTTLE) aborts to IDLE without a pop.
  - BASE in the same cycle as flush still completes the write.
  - Push in the same cycle as flush is discarded.

## Timing
- Reset values: all *_set_o=0, all data outputs=0, alloc_valid_o=0, done_valid_o=0, idx outputs=0, desc_ready_o=1, idle_o=1. FSM in IDLE, queue empty, owned=0.
- Reset asserted mid-sequence returns to IDLE next edge. No partial writes after reset.
- Push accepted at cycle t into an empty queue, free engine available:
  - IDLE pick at t+1
  - param set at t+2, throttle at t+3, base at t+4
  - alloc pulse at t+5
  - next pick no earlier than t+6
- Throughput: at most one descriptor per 5 cycles.
- Strobes are combinational from FSM state plus sw inputs. No registered output stage.
- done_valid_o is registered from owned/status: it pulses the cycle after the completion condition is first seen.

## Structure
- Add to hwpf_stride_pkg:
  - hwpf_stride_desc_t {base, param, throttle}
  - hwpf_stride_seq_state_e {IDLE, PARAM, THROTTLE, BASE, WAIT}
  - HWPF_STRIDE_STATUS_* bit-position localparams
- Sub-module: the descriptor queue is hpdcache_fifo_reg, instantiated with hwpf_stride_desc_t and a synchronous flush. Everything else is in hwpf_stride_seq.

## Test plan
- Single descriptor, status free idx=2: strobes param/throttle/base on engine 2 at t+2/t+3/t+4, base .enable=1; alloc_idx_o=2 at t+5.
- Fill 4 descriptors, status[31]=0: desc_ready_o=0 after the 4th push, no strobes. Assert status[31] with idx=0 → programming starts the next cycle, ready returns after the BASE pop.
- sw_param_set_i[1] during PARAM on idx 1: engine 1 receives sw data, FSM holds one cycle, then writes the queued param.
- sw_base_set_i[3] with enable=1 during THROTTLE on idx 3: abort, no pop. Next pick with free idx=0 programs engine 0 with the same descriptor.
- Owned engines 1 and 2 drop enable and busy in the same cycle: done pulses with idx 1 then idx 2 on consecutive cycles; idle_o=1 afterwards.
- flush_i with 3 queued, FSM in PARAM: no base strobe, count=0 next cycle, idle_o=1.
